ucsbece154b_issue_ctrl: RTL
===========================

# ucsbece154b_issue_ctrl

Parametrised N-wide in-order issue and hazard controller for the superscalar RISC-V pipeline. It sits between the decode stage and the execute pipeline registers. Per cycle it decides which decode slots of the current fetch group issue, and holds or replays the rest. It tracks per-slot destination/write/load state through E, M and W, and produces per-slot forwarding selects with source-slot indices, stall, flush and kill controls.

## Interface
- WIDTH, 2, issue slots per group (1..4)
- SW, $clog2(WIDTH) min 1, slot-index width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dec_valid_i  in  WIDTH  slot holds a valid decoded instruction
- dec_rd_i  in  5*WIDTH  destination register per slot
- dec_rs1_i, dec_rs2_i  in  5*WIDTH  source registers per slot
- dec_regwrite_i  in  WIDTH  slot writes rd
- dec_load_i  in  WIDTH  slot is a load (ResultSrc = 01)
- mispredict_i  in  1  branch/jump in E redirected fetch
- mispredict_slot_i  in  SW  slot in E that redirected
- issue_mask_o  out  WIDTH  slots entering E this cycle
- stall_fd_o  out  1  hold PC and D register
- flush_d_o  out  1  clear D register
- kill_e_o  out  WIDTH  E slots squashed before M
- fwd_a_o, fwd_b_o  out  2*WIDTH  per E slot: 10 mem, 01 wb, 00 regfile
- fwd_a_slot_o, fwd_b_slot_o  out  SW*WIDTH  producing slot of the selected stage

## Operation
- Internal pend_q[WIDTH] marks slots of the held D group not yet issued. Reset value is all ones.
- Candidate c[k] = dec_valid_i[k] & pend_q[k].
- Load-use: any candidate reads rs1 or rs2 equal to a nonzero rd of a valid E-stage load. In that case issue_mask_o = 0, stall_fd_o = 1, and pend_q is unchanged.
- Intra-group hazard for candidate k vs an older candidate j<k:
  - RAW: rs1 or rs2 of k equals rd of j, with rd_j != 0 and regwrite_j.
  - WAW: rd_k equals rd_j, with rd_j != 0 and both regwrite.
  - WAR is not a hazard, because operands are read in D.
- Issue: the lowest candidate always issues when there is no load-use. Higher candidates issue per Configuration.
- If any candidate remains unissued:
  - stall_fd_o = 1.
  - pend_q clears the issued bits.
- Otherwise pend_q returns to all ones and D advances.
- Slots not in issue_mask_o enter E as bubbles, with valid, regwrite and load all 0.
- E/M/W registers per slot hold valid, rd, regwrite and load. They advance every cycle and are never stalled.
- Mispredict:
  - flush_d_o = 1 and issue_mask_o = 0.
  - pend_q resets to all ones.
  - kill_e_o has bits set for slots > mispredict_slot_i.
  - Killed slots enter M with regwrite = 0.
  - Mispredict overrides load-use and partial issue; stall_fd_o = 0.
- Forwarding, per E slot and per source, when rs != 0:
  - Search M first, highest matching slot with regwrite: sel 10.
  - Else search W the same way: sel 01.
  - Else sel 00 with slot index 0.
  - Higher slot index within a stage is the younger instruction, so it wins.

## Timing
- issue_mask_o, stall_fd_o, flush_d_o, kill_e_o and fwd_* are combinational from inputs and registered state within the same cycle.
- Pipeline state updates on posedge clk. A D-stage instruction is visible to E-stage checks one cycle after issue.
- Reset values:
  - All E/M/W valid and regwrite bits are 0.
  - pend_q is all ones.
  - With all stage registers invalid, every output is 0.
- Reset mid-replay discards the partially issued group state.
- Worst-case group replay takes WIDTH cycles. A load-use stall adds exactly 1 cycle.
- Load-use coinciding with a partial group: the stall comes first, and pend_q holds.

## Configuration
- ISSUE_SPLIT_EN defined: issue the longest hazard-free prefix of the remaining candidates.
- Undefined: if any hazard exists among the candidates, issue only the lowest candidate and replay the rest one cycle later. The group is then re-evaluated.
- Hazard-free groups issue fully in both modes.

## Test plan
- WIDTH=2, slot0 `add x5,x1,x2`, slot1 `sub x6,x5,x3`, split on:
  - cycle0: issue_mask 01, stall 1.
  - cycle1: issue_mask 10, stall 0.
  - Slot1 in E shows fwd_a = 10 with slot 0.
- Load-use: `lw x7` in E slot1 and D slot0 reads x7 → issue_mask 00 and stall 1 for one cycle, then issue.
- WIDTH=4, RAW between slots 1 and 3 only:
  - With split: mask 0111 then 1000.
  - Without split: masks 0001, 0010, 0100, 1000.
- Mispredict with slot 0 in E and a partial group pending → flush_d 1, kill_e 1110, pend_q all ones next cycle, and no writeback from killed slots.
- Forward priority: x9 written by M slot0 and M slot1 and by W slot0 → select 10 with slot 1. A rd of x0 never forwards.
- Reset asserted mid-replay → next cycle all outputs are 0 and a new group issues fully.

Source files
------------

// File: rtl/ucsbece154b_issue_ctrl.sv
// N-wide in-order issue/hazard controller: selects issuing decode slots, replays the rest,
// tracks E/M/W per slot and drives forwarding selects. Optional feature macro: ISSUE_SPLIT_EN.
module ucsbece154b_issue_ctrl #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned SW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    dec_valid_i,
    input  logic [5*WIDTH-1:0]  dec_rd_i,
    input  logic [5*WIDTH-1:0]  dec_rs1_i,
    input  logic [5*WIDTH-1:0]  dec_rs2_i,
    input  logic [WIDTH-1:0]    dec_regwrite_i,
    input  logic [WIDTH-1:0]    dec_load_i,
    input  logic                mispredict_i,
    input  logic [SW-1:0]       mispredict_slot_i,
    output logic [WIDTH-1:0]    issue_mask_o,
    output logic                stall_fd_o,
    output logic                flush_d_o,
    output logic [WIDTH-1:0]    kill_e_o,
    output logic [2*WIDTH-1:0]  fwd_a_o,
    output logic [2*WIDTH-1:0]  fwd_b_o,
    output logic [SW*WIDTH-1:0] fwd_a_slot_o,
    output logic [SW*WIDTH-1:0] fwd_b_slot_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0]   r_pend;
    logic [WIDTH-1:0]   r_e_valid, r_e_regwrite, r_e_load;
    logic [5*WIDTH-1:0] r_e_rd, r_e_rs1, r_e_rs2;
    logic [WIDTH-1:0]   r_m_valid, r_m_regwrite;
    logic [5*WIDTH-1:0] r_m_rd;
    logic [WIDTH-1:0]   r_w_valid, r_w_regwrite;
    logic [5*WIDTH-1:0] r_w_rd;

    logic [WIDTH-1:0]   w_cand, w_older, w_haz, w_issue, w_remain, w_pend_nxt;
    logic               w_load_use;

    function automatic logic pair_hazard(input logic [4:0] rd_k, input logic [4:0] rs1_k,
                                         input logic [4:0] rs2_k, input logic wr_k,
                                         input logic [4:0] rd_j, input logic wr_j);
        return wr_j && (rd_j != 5'd0) &&
               ((rs1_k == rd_j) || (rs2_k == rd_j) || (wr_k && (rd_k == rd_j)));
    endfunction

    // Returns {sel, slot}; M is searched last so it overrides W, and ascending j lets the
    // younger (higher) slot win within a stage.
    function automatic logic [SW+1:0] fwd_pick(input logic [4:0] rs);
        logic [SW+1:0] sel;
        sel = '0;
        if (rs != 5'd0) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (r_w_valid[j] && r_w_regwrite[j] && (r_w_rd[5*j +: 5] == rs))
                    sel = {2'b01, SW'(j)};
            end
            for (int j = 0; j < WIDTH; j++) begin
                if (r_m_valid[j] && r_m_regwrite[j] && (r_m_rd[5*j +: 5] == rs))
                    sel = {2'b10, SW'(j)};
            end
        end
        return sel;
    endfunction

    assign w_cand = dec_valid_i & r_pend;

`ifdef ISSUE_SPLIT_EN
    assign w_older = w_cand;
`else
    // Already-issued slots still count as older, so a hazard keeps the remainder serial.
    assign w_older = dec_valid_i;
`endif

    always_comb begin
        w_haz = '0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (w_older[j] && pair_hazard(dec_rd_i[5*k +: 5], dec_rs1_i[5*k +: 5],
                                              dec_rs2_i[5*k +: 5], dec_regwrite_i[k],
                                              dec_rd_i[5*j +: 5], dec_regwrite_i[j]))
                    w_haz[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (w_cand[k] && r_e_valid[j] && r_e_load[j] && (r_e_rd[5*j +: 5] != 5'd0) &&
                    ((dec_rs1_i[5*k +: 5] == r_e_rd[5*j +: 5]) ||
                     (dec_rs2_i[5*k +: 5] == r_e_rd[5*j +: 5])))
                    w_load_use = 1'b1;
            end
        end
    end

`ifdef ISSUE_SPLIT_EN
    logic w_blocked;

    always_comb begin
        w_issue   = '0;
        w_blocked = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_cand[k]) begin
                if (w_haz[k]) w_blocked = 1'b1;
                if (!w_blocked) w_issue[k] = 1'b1;
            end
        end
    end
`else
    logic [WIDTH-1:0] w_lowest;

    assign w_lowest = w_cand & (~w_cand + WIDTH'(1));
    assign w_issue  = (|(w_cand & w_haz)) ? w_lowest : w_cand;
`endif

    assign w_remain = w_cand & ~w_issue;

    always_comb begin
        issue_mask_o = w_issue;
        stall_fd_o   = |w_remain;
        flush_d_o    = 1'b0;
        w_pend_nxt   = (|w_remain) ? (r_pend & ~w_issue) : ALL_ONES;
        if (mispredict_i) begin
            issue_mask_o = '0;
            stall_fd_o   = 1'b0;
            flush_d_o    = 1'b1;
            w_pend_nxt   = ALL_ONES;
        end else if (w_load_use) begin
            issue_mask_o = '0;
            stall_fd_o   = 1'b1;
            w_pend_nxt   = r_pend;
        end
    end

    always_comb begin
        kill_e_o = '0;
        for (int k = 0; k < WIDTH; k++) begin
            kill_e_o[k] = mispredict_i && (k > int'(mispredict_slot_i));
        end
    end

    always_comb begin
        fwd_a_o      = '0;
        fwd_b_o      = '0;
        fwd_a_slot_o = '0;
        fwd_b_slot_o = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (r_e_valid[k]) begin
                {fwd_a_o[2*k +: 2], fwd_a_slot_o[SW*k +: SW]} = fwd_pick(r_e_rs1[5*k +: 5]);
                {fwd_b_o[2*k +: 2], fwd_b_slot_o[SW*k +: SW]} = fwd_pick(r_e_rs2[5*k +: 5]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= ALL_ONES;
            r_e_valid    <= '0;
            r_e_regwrite <= '0;
            r_e_load     <= '0;
            r_e_rd       <= '0;
            r_e_rs1      <= '0;
            r_e_rs2      <= '0;
            r_m_valid    <= '0;
            r_m_regwrite <= '0;
            r_m_rd       <= '0;
            r_w_valid    <= '0;
            r_w_regwrite <= '0;
            r_w_rd       <= '0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_e_valid    <= issue_mask_o;
            r_e_regwrite <= issue_mask_o & dec_regwrite_i;
            r_e_load     <= issue_mask_o & dec_load_i;
            r_e_rd       <= dec_rd_i;
            r_e_rs1      <= dec_rs1_i;
            r_e_rs2      <= dec_rs2_i;
            r_m_valid    <= r_e_valid & ~kill_e_o;
            r_m_regwrite <= r_e_regwrite & ~kill_e_o;
            r_m_rd       <= r_e_rd;
            r_w_valid    <= r_m_valid;
            r_w_regwrite <= r_m_regwrite;
            r_w_rd       <= r_m_rd;
        end
    end

endmodule
